// File: rtl/m_mc_ctrl_if.sv
// Shared instruction/data memory port between the sequencer and memory.
// The request is a level held until the memory acknowledges.
interface m_mc_ctrl_if;
    logic w_mem_req;
    logic w_mem_we;
    logic w_mem_sel;
    logic w_ack;

    modport master (
        output w_mem_req,
        output w_mem_we,
        output w_mem_sel,
        input  w_ack
    );

    modport slave (
        input  w_mem_req,
        input  w_mem_we,
        input  w_mem_sel,
        output w_ack
    );
endinterface

// File: rtl/m_mc_ctrl.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXEC/MEM/WB over one memory port,
// with retire counter and sticky trap on memory timeout or illegal decode.
module m_mc_ctrl #(
    parameter int W_CNT   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             w_clk,
    input  logic             w_rst_n,
    input  logic             w_run,
    input  logic             w_r,
    input  logic             w_i,
    input  logic             w_s,
    input  logic             w_b,
    input  logic             w_u,
    input  logic             w_j,
    input  logic             w_ld,
    input  logic             w_taken,
    m_mc_ctrl_if.master      mem,
    output logic             w_ir_we,
    output logic             w_pc_we,
    output logic             w_pc_sel,
    output logic             w_rf_we,
    output logic [1:0]       w_wb_sel,
    output logic [2:0]       w_state,
    output logic [W_CNT-1:0] w_retired,
    output logic             w_err
);

    localparam int W_WAIT = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W_WAIT-1:0] WAIT_LAST = W_WAIT'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_ERR    = 3'd7
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [W_WAIT-1:0] wait_q;
    logic              mem_req;
    logic              mem_we;
    logic              mem_sel;
    logic              legal;
    logic              to_mem;
    logic              wait_hit;

    assign legal  = w_r | w_i | w_s | w_b | w_u | w_j;
    assign to_mem = w_s | w_ld;

    // Last permitted unacknowledged cycle; only meaningful while requesting.
    assign wait_hit = (TIMEOUT != 0) && !mem.w_ack && (wait_q == WAIT_LAST);

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            w_retired <= '0;
        end else begin
            state_q <= state_d;
            if (!mem_req || mem.w_ack) begin
                wait_q <= '0;
            end else begin
                wait_q <= wait_q + 1'b1;
            end
            if (w_pc_we) begin
                w_retired <= w_retired + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_sel  = 1'b0;
        w_ir_we  = 1'b0;
        w_pc_we  = 1'b0;
        w_pc_sel = 1'b0;
        w_rf_we  = 1'b0;
        w_wb_sel = 2'b00;
        w_err    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem_req = 1'b1;
                w_ir_we = mem.w_ack;
                if (mem.w_ack)    state_d = S_DECODE;
                else if (wait_hit) state_d = S_ERR;
            end
            S_DECODE: begin
                state_d = legal ? S_EXEC : S_ERR;
            end
            S_EXEC: begin
                state_d = to_mem ? S_MEM : S_WB;
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = w_s;
                // A store retires on its ack; there is no writeback.
                w_pc_we = w_s & mem.w_ack;
                if (mem.w_ack) begin
                    if (w_s) state_d = w_run ? S_FETCH : S_IDLE;
                    else     state_d = S_WB;
                end else if (wait_hit) begin
                    state_d = S_ERR;
                end
            end
            S_WB: begin
                w_pc_we  = 1'b1;
                w_rf_we  = ~(w_b | w_s);
                w_pc_sel = w_j | (w_b & w_taken);
                if (w_ld)     w_wb_sel = 2'b01;
                else if (w_j) w_wb_sel = 2'b10;
                state_d = w_run ? S_FETCH : S_IDLE;
            end
            S_ERR: begin
                w_err = 1'b1;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    assign mem.w_mem_req = mem_req;
    assign mem.w_mem_we  = mem_we;
    assign mem.w_mem_sel = mem_sel;
    assign w_state       = state_q;

endmodule

// File: doc/m_mc_ctrl.md
Name: m_mc_ctrl

Overview:
Multi-cycle sequencer for the RV32I datapath (PC adder, instruction/data memory, register file, operand mux, ALU adder).
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Lets one memory port be shared between instruction fetch and load/store.
- Generates every datapath enable and select, counts retired instructions, and traps memory timeouts and illegal decodes.

Parameters:
- W_CNT, 32: width of retired-instruction counter.
- TIMEOUT, 255: max cycles waiting for w_ack before error; 0 disables timeout.

Ports:
- w_clk  in  1  clock, all state updates on rising edge
- w_rst_n  in  1  asynchronous active-low reset
- w_run  in  1  permit starting a new instruction
- w_r, w_i, w_s, w_b, w_u, w_j, w_ld  in  1 each  decode class flags from immediate generator (w_ld qualifies w_i)
- w_taken  in  1  branch condition true (valid in EXEC)
- w_ack  in  1  shared memory acknowledge
- w_mem_req  out  1  memory request, level, held until ack
- w_mem_we  out  1  memory write (store)
- w_mem_sel  out  1  address select: 0 = PC, 1 = ALU result
- w_ir_we  out  1  latch instruction register
- w_pc_we  out  1  update PC
- w_pc_sel  out  1  next PC: 0 = PC+4, 1 = target
- w_rf_we  out  1  register file write
- w_wb_sel  out  2  writeback source: 00 = ALU, 01 = memory, 10 = PC+4
- w_state  out  3  current state encoding
- w_retired  out  W_CNT  retired instruction count
- w_err  out  1  sticky error flag

Behaviour:
- Reset is asynchronous and active-low. On reset: state = IDLE, w_retired = 0, wait counter = 0, w_err = 0, all enables/requests 0. Reset mid-request abandons the request immediately.
- State encodings: IDLE = 0, FETCH = 1, DECODE = 2, EXEC = 3, MEM = 4, WB = 5, ERR = 7.
- Outputs are Moore (decoded from the state register plus the flags listed below); no output depends on w_ack, except that w_ir_we and w_pc_we qualify with w_ack where noted.
- IDLE: all outputs 0. Go to FETCH when w_run = 1.
- FETCH: w_mem_req = 1, w_mem_sel = 0, w_mem_we = 0, w_ir_we = w_ack. On w_ack go to DECODE. Zero-wait ack (ack in first FETCH cycle) is legal.
- DECODE: one cycle, register file read.
  - If no class flag is set, go to ERR.
  - Otherwise go to EXEC.
- EXEC: one cycle, ALU operating.
  - w_s or w_ld set: go to MEM.
  - Otherwise: go to WB.
- MEM: w_mem_req = 1, w_mem_sel = 1, w_mem_we = w_s. Hold until w_ack.
  - Store: w_pc_we = w_ack, w_pc_sel = 0. On ack go to FETCH if w_run, else IDLE.
  - Load: on ack go to WB.
- WB: w_pc_we = 1.
  - w_rf_we = 1 unless w_b or w_s.
  - w_wb_sel = 01 if w_ld, 10 if w_j, else 00.
  - w_pc_sel = w_j | (w_b & w_taken).
  - Next state: FETCH if w_run, else IDLE.
- Decode flags and w_taken must stay stable from DECODE through WB (IR holds them).
- w_ack while w_mem_req = 0 is ignored.
- w_run is sampled only at instruction boundaries (IDLE, WB exit, store ack). Deasserting it mid-instruction does not abort.
- Retirement: w_retired increments by 1 on every cycle with w_pc_we = 1 and wraps modulo 2^W_CNT.
- Timeout: the wait counter clears on entry to FETCH/MEM and on ack, and increments each cycle w_mem_req = 1 and w_ack = 0. When it reaches TIMEOUT (and TIMEOUT != 0), go to ERR.
- ERR: all enables 0, w_err = 1, remain until reset.
- Latency with zero-wait memory:
  - ALU / LUI / JAL / branch: 4 cycles
  - load: 5 cycles
  - store: 4 cycles

Test Plan:
1. Reset low for 3 cycles, then high with w_run = 0 -> w_state = 0, all outputs 0, w_retired = 0. Raise w_run -> FETCH with w_mem_req = 1, w_mem_sel = 0 next cycle.
2. ADDI stream (w_i = 1), w_ack tied 1, w_run = 1 -> state sequence 1, 2, 3, 5 repeating. In WB: w_rf_we = 1, w_wb_sel = 00, w_pc_we = 1. After 10 instructions w_retired = 10 at cycle 40.
3. Load (w_i = 1, w_ld = 1) with ack delayed 3 cycles in MEM -> MEM held 4 cycles with w_mem_sel = 1, w_mem_we = 0. Then WB with w_wb_sel = 01, w_rf_we = 1. Store (w_s = 1) -> w_mem_we = 1, w_pc_we on ack, no WB state, w_rf_we never 1.
4. Branch (w_b = 1) with w_taken = 1 -> WB: w_pc_sel = 1, w_rf_we = 0. With w_taken = 0 -> w_pc_sel = 0. JAL (w_j = 1) -> w_pc_sel = 1, w_wb_sel = 10, w_rf_we = 1.
5. TIMEOUT = 4, w_ack held 0 in FETCH -> ERR (w_state = 7, w_err = 1) after 4 waiting cycles, stays there. Assert w_rst_n = 0 asynchronously mid-cycle -> immediate IDLE, w_err = 0.
6. All class flags 0 in DECODE -> ERR next cycle, w_retired unchanged. Separately: w_run dropped during EXEC -> instruction completes through WB, then IDLE.
